// File: rtl/usb_token_rx.sv
// USB token packet receiver: parses PID/byte1/byte2 from a phy byte stream,
// checks CRC5, filters on address/endpoint, and runs a packet-wait timer.
module usb_token_rx #(
    parameter int          TIMER_W    = 16,
    parameter int          ADDR_CHECK = 1,
    parameter logic [15:0] ENDP_MASK  = 16'hFFFF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         self_addr,
    input  logic [TIMER_W-1:0] time_threshold,
    input  logic               wait_start,
    input  logic               rx_lp_sop,
    input  logic               rx_lp_eop,
    input  logic               rx_lp_valid,
    input  logic [7:0]         rx_lp_data,
    output logic               rx_lp_ready,
    output logic               rx_pid_en,
    output logic [3:0]         rx_pid,
    output logic [3:0]         rx_endp,
    output logic [6:0]         rx_addr,
    output logic [10:0]        rx_frame,
    output logic               rx_sof,
    output logic               crc5_err,
    output logic               time_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        B1    = 2'd1,
        B2    = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [3:0]         PID_SOF = 4'b0101;
    localparam logic [TIMER_W-1:0] CNT_MAX = {TIMER_W{1'b1}};
    localparam logic [TIMER_W-1:0] CNT_ONE = {{(TIMER_W-1){1'b0}}, 1'b1};

    function automatic logic pid_valid(input logic [7:0] d);
        logic known;
        known = 1'b0;
        case (d[3:0])
            4'b0001, 4'b1001, 4'b1101, 4'b0101: known = 1'b1;
            default:                            known = 1'b0;
        endcase
        return known && (d[7:4] == ~d[3:0]);
    endfunction

    // Serial CRC5 over 11 data bits then 5 crc bits, LSB-first stream order.
    function automatic logic crc5_ok(input logic [15:0] stream);
        logic [4:0] r;
        logic       fb;
        r = 5'b11111;
        for (int i = 0; i < 16; i++) begin
            fb = r[4] ^ stream[i];
            r  = {r[3:0], 1'b0};
            if (fb) begin
                r = r ^ 5'b00101;
            end
        end
        return r == 5'b01100;
    endfunction

    state_t             state_r, state_s;
    logic [3:0]         pid_r, pid_s;
    logic [7:0]         b1_r, b1_s;
    logic               acc_s, sop_acc_s, accept_s;
    logic [6:0]         tok_addr_s;
    logic [3:0]         tok_endp_s;
    logic               pid_en_s, crc_err_s, sof_s;
    logic [3:0]         pid_out_s, endp_s;
    logic [6:0]         addr_s;
    logic [10:0]        frame_s;
    logic               armed_r, armed_s, to_s;
    logic [TIMER_W-1:0] cnt_r, cnt_s;

    // Ready is simply "out of reset"; there is no backpressure.
    assign rx_lp_ready = rst_n;
    assign acc_s       = rx_lp_valid & rx_lp_ready;
    assign sop_acc_s   = acc_s & rx_lp_sop;
    assign tok_addr_s  = b1_r[6:0];
    assign tok_endp_s  = {rx_lp_data[2:0], b1_r[7]};
    assign accept_s    = (pid_r == PID_SOF) ||
                         (ENDP_MASK[tok_endp_s] &&
                          ((ADDR_CHECK == 0) || (tok_addr_s == self_addr)));

    // Parser next-state and token output decode.
    always_comb begin
        state_s   = state_r;
        pid_s     = pid_r;
        b1_s      = b1_r;
        pid_en_s  = 1'b0;
        crc_err_s = 1'b0;
        pid_out_s = rx_pid;
        addr_s    = rx_addr;
        endp_s    = rx_endp;
        frame_s   = rx_frame;
        sof_s     = rx_sof;
        if (acc_s && rx_lp_sop) begin
            pid_s = rx_lp_data[3:0];
            if (rx_lp_eop) begin
                state_s = IDLE;
            end else if (pid_valid(rx_lp_data)) begin
                state_s = B1;
            end else begin
                state_s = DRAIN;
            end
        end else if (acc_s) begin
            case (state_r)
                IDLE: state_s = IDLE;
                B1: begin
                    if (rx_lp_eop) begin
                        state_s = IDLE;
                    end else begin
                        b1_s    = rx_lp_data;
                        state_s = B2;
                    end
                end
                B2: begin
                    if (rx_lp_eop) begin
                        state_s = IDLE;
                        if (!crc5_ok({rx_lp_data, b1_r})) begin
                            crc_err_s = 1'b1;
                        end else if (accept_s) begin
                            pid_en_s  = 1'b1;
                            pid_out_s = pid_r;
                            addr_s    = tok_addr_s;
                            endp_s    = tok_endp_s;
                            frame_s   = {rx_lp_data[2:0], b1_r};
                            sof_s     = (pid_r == PID_SOF);
                        end else begin
                            pid_en_s = 1'b0;
                        end
                    end else begin
                        state_s = DRAIN;
                    end
                end
                DRAIN: begin
                    if (rx_lp_eop) begin
                        state_s = IDLE;
                    end else begin
                        state_s = DRAIN;
                    end
                end
                default: state_s = IDLE;
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Packet-wait timer; wait_start takes priority over a same-cycle sop.
    always_comb begin
        armed_s = armed_r;
        cnt_s   = cnt_r;
        if (wait_start) begin
            armed_s = 1'b1;
            cnt_s   = {TIMER_W{1'b0}};
        end else if (sop_acc_s) begin
            armed_s = 1'b0;
        end else if (armed_r && (cnt_r == time_threshold)) begin
            armed_s = 1'b0;
        end else if (armed_r) begin
            if (cnt_r != CNT_MAX) begin
                cnt_s = cnt_r + CNT_ONE;
            end else begin
                cnt_s = cnt_r;
            end
        end else begin
            cnt_s = cnt_r;
        end
        to_s = armed_s && (cnt_s == time_threshold);
    end

    // State, capture and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            pid_r     <= 4'd0;
            b1_r      <= 8'd0;
            armed_r   <= 1'b0;
            cnt_r     <= {TIMER_W{1'b0}};
            rx_pid_en <= 1'b0;
            rx_pid    <= 4'd0;
            rx_endp   <= 4'd0;
            rx_addr   <= 7'd0;
            rx_frame  <= 11'd0;
            rx_sof    <= 1'b0;
            crc5_err  <= 1'b0;
            time_out  <= 1'b0;
        end else begin
            state_r   <= state_s;
            pid_r     <= pid_s;
            b1_r      <= b1_s;
            armed_r   <= armed_s;
            cnt_r     <= cnt_s;
            rx_pid_en <= pid_en_s;
            rx_pid    <= pid_out_s;
            rx_endp   <= endp_s;
            rx_addr   <= addr_s;
            rx_frame  <= frame_s;
            rx_sof    <= sof_s;
            crc5_err  <= crc_err_s;
            time_out  <= to_s;
        end
    end

endmodule
